perceptron_trainer: RTL

- Parametrised training/inference sequencer for one Perceptron instance, driven from a synthesisable top.
- Trains the perceptron on an INPUT_UNITS-input boolean truth table for EPOCHS passes and drives the binary-cross-entropy gradient.
- Then switches to inference: registered user inputs go to the perceptron, and a thresholded prediction comes back out.
- Replaces the open-loop stimulus approach with a clocked FSM: reset/start handshake, settle counter, retrain support.

---
 rtl/fixed_point_pkg.sv | 55 +++++
 rtl/perceptron_trainer_pkg.sv | 27 ++
 rtl/perceptron_trainer_rom.sv | 22 ++
 rtl/perceptron_trainer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Signed Q8.8 fixed-point type with saturating add/sub/div helpers.
// Results that overflow clamp to the most positive or most negative code.
package fixed_point_pkg;

  localparam int SFP_W    = 16;
  localparam int SFP_FRAC = 8;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp ONE     = 16'sh0100;
  localparam sfp HALF    = 16'sh0080;
  localparam sfp epsilon = 16'sh0001;
  localparam sfp SFP_MAX = 16'sh7fff;
  localparam sfp SFP_MIN = 16'sh8000;

  function automatic sfp sfp_sat(input logic signed [31:0] x);
    if (x > 32'sd32767) begin
      return SFP_MAX;
    end else if (x < -32'sd32768) begin
      return SFP_MIN;
    end
    return x[SFP_W-1:0];
  endfunction

  function automatic sfp sfp_add(input sfp a, input sfp b);
    logic signed [31:0] s;
    s = 32'(a) + 32'(b);
    return sfp_sat(s);
  endfunction

  function automatic sfp sfp_sub(input sfp a, input sfp b);
    logic signed [31:0] s;
    s = 32'(a) - 32'(b);
    return sfp_sat(s);
  endfunction

  // Quotient truncates toward zero; a zero divisor saturates by the numerator's sign.
  function automatic sfp sfp_div(input sfp num, input sfp den);
    logic signed [31:0] n;
    logic signed [31:0] d;
    n = 32'(num) <<< SFP_FRAC;
    d = 32'(den);
    if (den == '0) begin
      return (num < 0) ? SFP_MIN : SFP_MAX;
    end
    return sfp_sat(n / d);
  endfunction

  function automatic sfp int_to_sfp(input int i);
    logic signed [31:0] v;
    v = 32'(i) <<< SFP_FRAC;
    return sfp_sat(v);
  endfunction

endpackage

// File: rtl/perceptron_trainer_pkg.sv
// Trainer state encoding and the binary-cross-entropy gradient shared by output layers.
// The gradient is purely combinational and saturating.
package perceptron_trainer_pkg;

  import fixed_point_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_APPLY,
    S_SETTLE,
    S_UPDATE,
    S_INFER
  } trainer_state_e;

  // dL/dp of BCE, with epsilon keeping both divisors away from zero.
  function automatic sfp bce_gradient(input sfp expected, input sfp prediction);
    sfp p_eps;
    sfp pos_term;
    sfp neg_term;
    p_eps    = sfp_add(prediction, epsilon);
    pos_term = sfp_div(expected, p_eps);
    neg_term = sfp_div(sfp_sub(ONE, expected), sfp_sub(ONE, p_eps));
    return sfp_sub(neg_term, pos_term);
  endfunction

endpackage

// File: rtl/perceptron_trainer_rom.sv
// Truth-table lookup: sample index to perceptron input vector and target value.
// Combinational, no state; values[0] carries the most significant index bit.
module truth_table_rom
  import fixed_point_pkg::*;
#(
  parameter int                          INPUT_UNITS  = 2,
  parameter logic [(2**INPUT_UNITS)-1:0] TARGET_TABLE = 4'b1000
) (
  input  logic [INPUT_UNITS-1:0] sample_idx_i,
  output sfp   [INPUT_UNITS-1:0] values_o,
  output sfp                     expected_o
);

  always_comb begin
    values_o = '0;
    for (int i = 0; i < INPUT_UNITS; i++) begin
      values_o[i] = sample_idx_i[INPUT_UNITS-1-i] ? ONE : '0;
    end
    expected_o = TARGET_TABLE[sample_idx_i] ? ONE : '0;
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Clocked train-then-infer sequencer for one perceptron; start accepted only in IDLE or INFER.
// Per-sample period SETTLE_CYCLES+2; inference result lags user_inputs by two cycles.
module perceptron_trainer
  import fixed_point_pkg::*;
  import perceptron_trainer_pkg::*;
#(
  parameter int                          INPUT_UNITS   = 2,
  parameter int                          EPOCHS        = 10,
  parameter logic [(2**INPUT_UNITS)-1:0] TARGET_TABLE  = 4'b1000,
  parameter int                          SETTLE_CYCLES = 2,
  localparam int                         EPOCH_W       = $clog2(EPOCHS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear_weights,
  input  logic [INPUT_UNITS-1:0] user_inputs,
  input  sfp                     prediction,
  output logic                   perc_rst,
  output sfp   [INPUT_UNITS-1:0] values,
  output sfp                     expected,
  output logic                   training,
  output sfp                     error_gradient,
  output logic                   busy,
  output logic                   done,
  output logic [EPOCH_W-1:0]     epoch_count,
  output logic [INPUT_UNITS-1:0] sample_idx,
  output logic                   output_led
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  trainer_state_e state_q, state_d;
  logic [INPUT_UNITS-1:0] sample_q, sample_d;
  logic [EPOCH_W-1:0]     epoch_q, epoch_d;
  logic [SETTLE_W-1:0]    settle_q, settle_d;
  sfp [INPUT_UNITS-1:0]   values_q, values_d;
  sfp                     expected_q, expected_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   led_q, led_d;

  sfp [INPUT_UNITS-1:0]   rom_values;
  sfp                     rom_expected;
  logic                   start_ok;

  truth_table_rom #(
    .INPUT_UNITS  (INPUT_UNITS),
    .TARGET_TABLE (TARGET_TABLE)
  ) u_rom (
    .sample_idx_i (sample_q),
    .values_o     (rom_values),
    .expected_o   (rom_expected)
  );

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_INFER));

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    epoch_d    = epoch_q;
    settle_d   = settle_q;
    values_d   = values_q;
    expected_d = expected_q;
    busy_d     = busy_q;
    done_d     = done_q;
    led_d      = 1'b0;

    case (state_q)
      S_CLEAR: state_d = S_APPLY;
      S_APPLY: begin
        values_d   = rom_values;
        expected_d = rom_expected;
        settle_d   = SETTLE_W'(SETTLE_CYCLES - 1);
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_UPDATE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_UPDATE: begin
        sample_d = sample_q + 1'b1;
        state_d  = S_APPLY;
        if (sample_q == '1) begin
          epoch_d = epoch_q + 1'b1;
          if (epoch_d == EPOCH_W'(EPOCHS)) begin
            state_d = S_INFER;
          end
        end
      end
      S_INFER: begin
        for (int i = 0; i < INPUT_UNITS; i++) begin
          values_d[i] = user_inputs[INPUT_UNITS-1-i] ? ONE : '0;
        end
        led_d = (prediction > HALF);
        // First INFER cycle hands over from busy to done.
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (start_ok) begin
      state_d  = clear_weights ? S_CLEAR : S_APPLY;
      sample_d = '0;
      epoch_d  = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      led_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sample_q   <= '0;
      epoch_q    <= '0;
      settle_q   <= '0;
      values_q   <= '0;
      expected_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      epoch_q    <= epoch_d;
      settle_q   <= settle_d;
      values_q   <= values_d;
      expected_q <= expected_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      led_q      <= led_d;
    end
  end

  assign perc_rst       = rst || (state_q == S_CLEAR);
  assign training       = (state_q == S_SETTLE);
  assign error_gradient = training ? bce_gradient(expected_q, prediction) : '0;
  assign values         = values_q;
  assign expected       = expected_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign epoch_count    = epoch_q;
  assign sample_idx     = sample_q;
  assign output_led     = led_q;

endmodule
